// File: rtl/mem_access_arbiter_if.sv
// Request/response channels for both requesters plus the data-memory bus.
// slave  : seen from the arbiter.
// master : seen from the requesters and the memory model.
interface mem_access_arbiter_if #(parameter int ADDR_W = 32);
  logic              r0_valid, r0_ready, r0_write, r0_is32;
  logic [ADDR_W-1:0] r0_addr;
  logic [31:0]       r0_wdata;
  logic              r0_resp_valid, r0_resp_err;
  logic [31:0]       r0_resp_rdata;

  logic              r1_valid, r1_ready, r1_write, r1_is32;
  logic [ADDR_W-1:0] r1_addr;
  logic [31:0]       r1_wdata;
  logic              r1_resp_valid, r1_resp_err;
  logic [31:0]       r1_resp_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write_enable, mem_is32bitWrite;
  logic [7:0]        mem_bus_to_mem;
  logic [31:0]       mem_bus_to_mem_32;
  logic [7:0]        mem_bus_from_mem;
  logic [31:0]       mem_bus_from_mem_32;

  modport slave (
    input  r0_valid, r0_write, r0_is32, r0_addr, r0_wdata,
    output r0_ready, r0_resp_valid, r0_resp_rdata, r0_resp_err,
    input  r1_valid, r1_write, r1_is32, r1_addr, r1_wdata,
    output r1_ready, r1_resp_valid, r1_resp_rdata, r1_resp_err,
    output mem_addr, mem_write_enable, mem_is32bitWrite, mem_bus_to_mem, mem_bus_to_mem_32,
    input  mem_bus_from_mem, mem_bus_from_mem_32
  );

  modport master (
    output r0_valid, r0_write, r0_is32, r0_addr, r0_wdata,
    input  r0_ready, r0_resp_valid, r0_resp_rdata, r0_resp_err,
    output r1_valid, r1_write, r1_is32, r1_addr, r1_wdata,
    input  r1_ready, r1_resp_valid, r1_resp_rdata, r1_resp_err,
    input  mem_addr, mem_write_enable, mem_is32bitWrite, mem_bus_to_mem, mem_bus_to_mem_32,
    output mem_bus_from_mem, mem_bus_from_mem_32
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared data memory.
// One access per three cycles: accept (IDLE) -> memory cycle (ACCESS) ->
// response strobe (RESP).
// Optional build macro MEM_ARB_ALIGN_CHECK_EN: misaligned 32-bit accesses
// are accepted but never reach memory and respond with resp_err=1, rdata=0.
module mem_access_arbiter #(
  parameter int ADDR_W = 32
) (
  input logic               clk,
  input logic               rst,
  mem_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              rr_q;        // requester favoured on the next tie
  logic              id_q;        // requester owning the current access
  logic              write_q, is32_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0][31:0]  rdata_q;     // per-requester, holds between strobes
  logic [1:0]        err_q;
  logic [1:0]        req_vld;
  logic              gnt, gnt_id, access, resp, misal;
  logic [31:0]       rdata_d;

  assign req_vld = {bus.r1_valid, bus.r0_valid};

  // Grant only from IDLE; a lone requester wins outright, a tie goes to rr_q.
  always_comb begin
    gnt    = (state_q == IDLE) && !rst && (req_vld != 2'b00);
    gnt_id = (&req_vld) ? rr_q : req_vld[1];
  end

  assign access = (state_q == ACCESS) && !rst;
  assign resp   = (state_q == RESP) && !rst;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign misal = is32_q && (addr_q[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  // Read data captured from memory; writes and rejected accesses return 0.
  always_comb begin
    rdata_d = 32'h0;
    if (!write_q && !misal)
      rdata_d = is32_q ? bus.mem_bus_from_mem_32 : {24'h0, bus.mem_bus_from_mem};
  end

  // Next-state logic: every non-IDLE state lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any access in flight without a response.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latch on grant, response capture during the memory cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      write_q <= 1'b0;
      is32_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= '0;
      err_q   <= 2'b00;
    end else begin
      if (gnt) begin
        id_q    <= gnt_id;
        rr_q    <= ~gnt_id;
        write_q <= gnt_id ? bus.r1_write : bus.r0_write;
        is32_q  <= gnt_id ? bus.r1_is32  : bus.r0_is32;
        addr_q  <= gnt_id ? bus.r1_addr  : bus.r0_addr;
        wdata_q <= gnt_id ? bus.r1_wdata : bus.r0_wdata;
      end
      if (access) begin
        rdata_q[id_q] <= rdata_d;
        err_q[id_q]   <= misal;
      end
    end
  end

  assign bus.r0_ready      = gnt && !gnt_id;
  assign bus.r1_ready      = gnt &&  gnt_id;
  assign bus.r0_resp_valid = resp && !id_q;
  assign bus.r1_resp_valid = resp &&  id_q;
  assign bus.r0_resp_rdata = rdata_q[0];
  assign bus.r1_resp_rdata = rdata_q[1];
  assign bus.r0_resp_err   = err_q[0];
  assign bus.r1_resp_err   = err_q[1];

  // Memory bus is driven only during the access cycle, zero otherwise.
  assign bus.mem_addr          = access ? addr_q : '0;
  assign bus.mem_is32bitWrite  = access && is32_q;
  assign bus.mem_write_enable  = access && write_q && !misal;
  assign bus.mem_bus_to_mem    = access ? wdata_q[7:0] : 8'h0;
  assign bus.mem_bus_to_mem_32 = access ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_mem_access_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  always #5 clk = ~clk;

  mem_access_arbiter_if #(.ADDR_W(32)) bus();
  mem_access_arbiter #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef MEM_ARB_ALIGN_CHECK_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] emem    [256];   // memory environment (the real "RAM")
  logic [7:0] ref_mem [256];   // reference model's view of memory

  function automatic logic [7:0] idx(input logic [31:0] a, input int k);
    return 8'(a[7:0] + 8'(k));
  endfunction

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  // Byte-addressable little-endian memory with combinational read.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) emem[i] <= init_byte(i);
    end else if (bus.mem_write_enable) begin
      emem[idx(bus.mem_addr, 0)] <= bus.mem_is32bitWrite ? bus.mem_bus_to_mem_32[7:0] : bus.mem_bus_to_mem;
      if (bus.mem_is32bitWrite) begin
        emem[idx(bus.mem_addr, 1)] <= bus.mem_bus_to_mem_32[15:8];
        emem[idx(bus.mem_addr, 2)] <= bus.mem_bus_to_mem_32[23:16];
        emem[idx(bus.mem_addr, 3)] <= bus.mem_bus_to_mem_32[31:24];
      end
    end
  end

  always_comb begin
    bus.mem_bus_from_mem    = emem[idx(bus.mem_addr, 0)];
    bus.mem_bus_from_mem_32 = {emem[idx(bus.mem_addr, 3)], emem[idx(bus.mem_addr, 2)],
                               emem[idx(bus.mem_addr, 1)], emem[idx(bus.mem_addr, 0)]};
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic w, input logic s,
                         input logic [31:0] a, input logic [31:0] d);
    if (id == 0) begin
      bus.r0_valid = v; bus.r0_write = w; bus.r0_is32 = s; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_valid = v; bus.r1_write = w; bus.r1_is32 = s; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  function automatic logic [1:0] rdy();
    return {bus.r1_ready, bus.r0_ready};
  endfunction
  function automatic logic [1:0] rv();
    return {bus.r1_resp_valid, bus.r0_resp_valid};
  endfunction
  function automatic logic [31:0] rdata(input int id);
    return (id == 0) ? bus.r0_resp_rdata : bus.r1_resp_rdata;
  endfunction
  function automatic logic rerr(input int id);
    return (id == 0) ? bus.r0_resp_err : bus.r1_resp_err;
  endfunction

  // ---- reference model: outcome of one serialized access ----
  function automatic logic misal_m(input logic s, input logic [31:0] a);
    return AL && s && (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_read(input logic s, input logic [31:0] a);
    if (s) return {ref_mem[idx(a, 3)], ref_mem[idx(a, 2)], ref_mem[idx(a, 1)], ref_mem[idx(a, 0)]};
    return {24'h0, ref_mem[idx(a, 0)]};
  endfunction

  task automatic ref_access(input logic w, input logic s, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic e, output logic we);
    e  = misal_m(s, a);
    rd = 32'h0;
    we = w && !e;
    if (!e) begin
      if (w) begin
        ref_mem[idx(a, 0)] = d[7:0];
        if (s) begin
          ref_mem[idx(a, 1)] = d[15:8];
          ref_mem[idx(a, 2)] = d[23:16];
          ref_mem[idx(a, 3)] = d[31:24];
        end
      end else begin
        rd = ref_read(s, a);
      end
    end
  endtask

  // One isolated transaction: accept at T, memory at T+1, response at T+2.
  task automatic do_txn(input int id, input logic w, input logic s, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_we, input logic [31:0] exp_rd,
                        input logic exp_err, output int waited);
    @(negedge clk);
    set_req(id, 1'b1, w, s, a, d);
    #1;
    waited = 0;
    while (!(id == 0 ? bus.r0_ready : bus.r1_ready) && waited < 8) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!(id == 0 ? bus.r0_ready : bus.r1_ready)) begin
      n_chk++; n_err++;
      $display("FAIL txn_ready_timeout: requester %0d never got ready", id);
      set_req(id, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      return;
    end
    chk("txn_ready_onehot", 32'(rdy()), (id == 0) ? 32'd1 : 32'd2);
    @(negedge clk);
    set_req(id, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("access_we", 32'(bus.mem_write_enable), 32'(exp_we));
    chk("access_addr", bus.mem_addr, a);
    chk("access_is32", 32'(bus.mem_is32bitWrite), 32'(s));
    if (exp_we)
      chk("access_wdata", s ? bus.mem_bus_to_mem_32 : {24'h0, bus.mem_bus_to_mem},
          s ? d : {24'h0, d[7:0]});
    @(negedge clk); #1;
    chk("resp_valid", 32'(rv()), (id == 0) ? 32'd1 : 32'd2);
    chk("resp_rdata", rdata(id), exp_rd);
    chk("resp_err", 32'(rerr(id)), 32'(exp_err));
    @(negedge clk); #1;
    chk("resp_after", 32'(rv()), 32'd0);
  endtask

  typedef struct {
    int          id;
    logic        w, s;
    logic [31:0] a, d;
    logic        we;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t        tbl[$];
  int          waited;
  logic [31:0] m_rd;
  logic        m_e, m_we;
  logic [1:0]  p, pw, ps;
  logic [31:0] pa[2], pd[2];
  logic        rr_m;
  int          since, resp_at, resp_id, acc_at, g;
  logic [31:0] resp_rd;
  logic        resp_e, acc_we;
  logic [1:0]  exp_rdy, exp_rv;

  initial begin
    // ---- directed vectors (accesses in order, single requester each) ----
    tbl.push_back('{0, 1'b1, 1'b0, 32'h10, 32'hA5,       1'b1, 32'h0,        1'b0});
    tbl.push_back('{0, 1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hA5,       1'b0});
    tbl.push_back('{1, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0});
    tbl.push_back('{1, 1'b0, 1'b0, 32'h21, 32'h0,        1'b0, 32'hBE,       1'b0});
    tbl.push_back('{0, 1'b0, 1'b1, 32'h20, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{0, 1'b1, 1'b1, 32'h42, 32'h12345678, !AL,  32'h0,        AL});
    tbl.push_back('{0, 1'b0, 1'b0, 32'h42, 32'h0,        1'b0, AL ? 32'h18 : 32'h78, 1'b0});
    tbl.push_back('{1, 1'b0, 1'b1, 32'h41, 32'h0,        1'b0, AL ? 32'h0 : 32'h3456781B, AL});
    tbl.push_back('{1, 1'b1, 1'b0, 32'hFFFF_FF07, 32'h3C, 1'b1, 32'h0,       1'b0});
    tbl.push_back('{0, 1'b0, 1'b0, 32'h07, 32'h0,        1'b0, 32'h3C,       1'b0});

    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);

    // ---- reset state, with requests pending to prove ready is held off ----
    rst = 1'b1; mem_init = 1'b1;
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h55);
    set_req(1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", 32'(rdy()), 32'd0);
    chk("reset_resp_valid", 32'(rv()), 32'd0);
    chk("reset_mem_we", 32'(bus.mem_write_enable), 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'h0);
    chk("reset_rdata0", bus.r0_resp_rdata, 32'h0);
    chk("reset_rdata1", bus.r1_resp_rdata, 32'h0);
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0; mem_init = 1'b0;

    foreach (tbl[i]) begin
      ref_access(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, m_rd, m_e, m_we);
      do_txn(tbl[i].id, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].we, tbl[i].rd, tbl[i].err, waited);
    end

    // ---- reset during the memory cycle of a write ----
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h11);
    #1;
    chk("rstmid_accept", 32'(bus.r0_ready), 32'd1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    chk("rstmid_we_gated", 32'(bus.mem_write_enable), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_no_resp", 32'(rv()), 32'd0);
    do_txn(1, 1'b0, 1'b0, 32'h30, 32'h0, 1'b0, {24'h0, init_byte(8'h30)}, 1'b0, waited);
    chk("rstmid_idle_next", 32'(waited), 32'd0);

    // ---- both requesters valid from reset: strict alternation ----
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      chk("rr_alternate", 32'({rv(), rdy()}),
          32'({(c % 6) == 5, (c % 6) == 2, (c % 6) == 3, (c % 6) == 0}));
      if ((c % 6) == 2) chk("rr_r0_rdata", bus.r0_resp_rdata, ref_read(1'b0, 32'h10));
      if ((c % 6) == 5) chk("rr_r1_rdata", bus.r1_resp_rdata, ref_read(1'b1, 32'h20));
    end

    // ---- only r1 requesting while the pointer favours r0 ----
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      chk("solo_r1", 32'({rv(), rdy()}), 32'({(c % 3) == 2, 1'b0, (c % 3) == 0, 1'b0}));
      if ((c % 3) == 2) chk("solo_r1_rdata", bus.r1_resp_rdata, ref_read(1'b1, 32'h20));
    end
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // ---- randomized contention against the transaction-level model ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_m = 1'b0; since = 3; resp_at = -1; acc_at = -1; resp_id = 0;
    resp_rd = 32'h0; resp_e = 1'b0; acc_we = 1'b0;
    p = 2'b00; pw = 2'b00; ps = 2'b00; pa[0] = 0; pa[1] = 0; pd[0] = 0; pd[1] = 0;
    for (int c = 0; c < 400; c++) begin
      if (c != 0) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!p[i] && $urandom_range(0, 2) == 0) begin
          p[i] = 1'b1; pw[i] = 1'($urandom); ps[i] = 1'($urandom);
          pa[i] = $urandom; pd[i] = $urandom;
        end else if (p[i] && $urandom_range(0, 15) == 0) begin
          p[i] = 1'b0;
        end
        set_req(i, p[i], pw[i], ps[i], pa[i], pd[i]);
      end
      #1;
      exp_rdy = 2'b00;
      g = -1;
      if (since >= 3 && p != 2'b00) begin
        g = (p == 2'b11) ? int'(rr_m) : int'(p[1]);
        exp_rdy[g] = 1'b1;
      end
      exp_rv = 2'b00;
      if (resp_at == c) exp_rv[resp_id] = 1'b1;
      chk("rnd_ready", 32'(rdy()), 32'(exp_rdy));
      chk("rnd_resp_valid", 32'(rv()), 32'(exp_rv));
      chk("rnd_mem_we", 32'(bus.mem_write_enable), 32'((acc_at == c) && acc_we));
      if (resp_at == c) begin
        chk("rnd_rdata", rdata(resp_id), resp_rd);
        chk("rnd_err", 32'(rerr(resp_id)), 32'(resp_e));
      end
      if (g >= 0) begin
        ref_access(pw[g], ps[g], pa[g], pd[g], resp_rd, resp_e, acc_we);
        resp_id = g; resp_at = c + 2; acc_at = c + 1;
        rr_m = ~1'(g); since = 0; p[g] = 1'b0;
      end
      since++;
    end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared single-port, byte-addressable data memory.
- The memory has an 8-bit/32-bit write path and combinational read.
- Requester 0 is instruction fetch; requester 1 is load/store. Each uses a valid/ready request channel and a one-cycle response strobe.
- The block serialises the requesters with round-robin priority and drives the memory's address, write-enable, width-select and data buses.

Parameters:
ADDR_W, 32, width of request and memory address.

Ports:
clk  in  1  system clock, all state on posedge.
rst  in  1  synchronous reset, active-high.
rN_valid  in  1  request valid, requester N (N=0,1).
rN_ready  out  1  request accepted this cycle.
rN_write  in  1  1=write, 0=read.
rN_is32  in  1  1=32-bit access, 0=8-bit access.
rN_addr  in  ADDR_W  byte address.
rN_wdata  in  32  write data; bits [7:0] only for 8-bit access.
rN_resp_valid  out  1  one-cycle completion strobe (reads and writes).
rN_resp_rdata  out  32  read data, valid with resp_valid.
rN_resp_err  out  1  access rejected, valid with resp_valid.
mem_addr  out  ADDR_W  memory byte address.
mem_write_enable  out  1  memory write strobe.
mem_is32bitWrite  out  1  memory width select.
mem_bus_to_mem  out  8  byte write data.
mem_bus_to_mem_32  out  32  word write data.
mem_bus_from_mem  in  8  byte read data.
mem_bus_from_mem_32  in  32  word read data.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, rr_ptr=0 (requester 0 favoured next).
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no valid: stay in IDLE.
- IDLE, one valid: grant it.
- IDLE, both valid: grant requester rr_ptr.
- On grant:
  - rN_ready=1 combinationally in that same cycle.
  - Latch write, is32, addr, wdata and granted id.
  - rr_ptr <= ~id.
  - Next state ACCESS.
- rN_ready is 1 only in IDLE on the granted requester. At most one ready per cycle.
- Requester holds valid and fields stable until ready. Dropping valid before ready is legal; no side effect.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr.
  - mem_is32bitWrite = latched is32.
  - mem_bus_to_mem = wdata[7:0]; mem_bus_to_mem_32 = wdata.
  - mem_write_enable = latched write & ~rst.
  - Read data register <= is32 ? mem_bus_from_mem_32 : {24'b0, mem_bus_from_mem}.
  - Next state RESP.
- RESP (1 cycle):
  - rID_resp_valid=1 with registered rdata and err.
  - Write responses return rdata=0.
  - Next state IDLE.
- Outside ACCESS, all mem_* outputs are 0.
- Timing: accept at cycle T, memory access at T+1, resp_valid at T+2. Next accept at T+3 at earliest (one access per 3 cycles).
- resp_rdata and resp_err hold their last values between strobes. Only resp_valid qualifies them.
- Reset mid-operation: returns to IDLE next cycle. No response is issued. A write in ACCESS during the reset cycle is suppressed (write-enable gated by rst).
- Address wrap: no arithmetic on addresses. The memory bounds the address range.

Optional Feature:
MEM_ARB_ALIGN_CHECK_EN
- Defined:
  - A 32-bit request with addr[1:0]!=0 is still accepted normally (ready, FSM path and latency unchanged).
  - In ACCESS, mem_write_enable is forced 0 and rdata=0.
  - In RESP, resp_err=1.
- Undefined:
  - Misaligned 32-bit accesses pass straight to memory.
  - resp_err is constant 0.

Test Plan:
1. r0 write, is32=0, addr=0x10, wdata=0xA5. Then r0 read, is32=0, addr=0x10 -> mem_write_enable high exactly at T+1; read resp at T+2 with rdata=0x000000A5, err=0.
2. r1 write, is32=1, addr=0x20, data=0xDEADBEEF. Then 8-bit read at 0x21 -> rdata=0x000000BE.
3. r0 and r1 valid continuously from reset -> grants go r0, r1, r0, r1, one ready every 3 cycles; each resp_valid on the granted requester only.
4. rst asserted in the ACCESS cycle of a write to 0x30, data 0x11 -> mem_write_enable=0, no resp_valid, FSM in IDLE next cycle, later read of 0x30 returns the prior value.
5. Only r1 valid, back-to-back 4 reads -> r1 granted every 3 cycles despite rr_ptr pointing to r0.
6. With MEM_ARB_ALIGN_CHECK_EN: r0 32-bit write to addr=0x42 -> no memory write, resp_err=1, rdata=0. Without the macro, same stimulus -> write occurs, err=0.
